// File: rtl/issue_queue_pkg.sv
// Shared types and helpers for the age-ordered collapsing issue queue.
// Entry payload widths are fixed by the package constants below.
package issue_pkg;

    localparam int PREG_BITS_DEFAULT = 7;
    localparam int CTRL_BITS_DEFAULT = 16;
    localparam int WAKEUP_PORTS_MAX  = 8;
    localparam int WK_PDST_W         = WAKEUP_PORTS_MAX * PREG_BITS_DEFAULT;

    typedef struct packed {
        logic                         valid;
        logic [PREG_BITS_DEFAULT-1:0] src1;
        logic                         p1;
        logic [PREG_BITS_DEFAULT-1:0] src2;
        logic                         p2;
        logic [CTRL_BITS_DEFAULT-1:0] ctrl;
    } iq_entry_t;

    // Unused ports are zero-padded by the caller, so their valid bits never hit.
    function automatic logic match_any(
        input logic [PREG_BITS_DEFAULT-1:0] tag,
        input logic [WAKEUP_PORTS_MAX-1:0]  wk_vld,
        input logic [WK_PDST_W-1:0]         wk_pdst
    );
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < WAKEUP_PORTS_MAX; k++) begin
            if (wk_vld[k] && (wk_pdst[k*PREG_BITS_DEFAULT +: PREG_BITS_DEFAULT] == tag))
                hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/issue_queue_entry.sv
// One issue-queue slot: hold / shift-in from the slot above / dispatch write, with wakeup.
// State updates on the next edge; ready reflects registered state only.
module iq_entry
    import issue_pkg::*;
(
    input  logic                        clk,
    input  logic                        i_reset,
    input  logic                        i_flush,
    input  logic                        i_shift,
    input  logic                        i_write,
    input  iq_entry_t                   i_upper,
    input  iq_entry_t                   i_disp,
    input  logic [WAKEUP_PORTS_MAX-1:0] i_wk_vld,
    input  logic [WK_PDST_W-1:0]        i_wk_pdst,
    output iq_entry_t                   o_entry,
    output logic                        o_ready
);

    iq_entry_t r_entry;
    iq_entry_t w_base;
    iq_entry_t w_next;

    // Wakeup is applied after the mux so shifted and dispatched entries never miss a broadcast.
    always_comb begin
        w_base = r_entry;
        if (i_write)
            w_base = i_disp;
        else if (i_shift)
            w_base = i_upper;
        w_next = w_base;
        if (w_base.valid) begin
            w_next.p1 = w_base.p1 | match_any(w_base.src1, i_wk_vld, i_wk_pdst);
            w_next.p2 = w_base.p2 | match_any(w_base.src2, i_wk_vld, i_wk_pdst);
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset || i_flush)
            r_entry <= '0;
        else
            r_entry <= w_next;
    end

    assign o_entry = r_entry;
    assign o_ready = r_entry.valid & r_entry.p1 & r_entry.p2;

endmodule

// File: rtl/issue_queue.sv
// Age-ordered collapsing issue queue: oldest-ready select, one dispatch and one issue per cycle.
// Wakeup-to-issue is one cycle; disp_ready drops when full and ignores a same-cycle issue.
module issue_queue
    import issue_pkg::*;
#(
    parameter int NUM_SLOTS        = 8,
    parameter int NUM_WAKEUP_PORTS = 2,
    parameter int PREG_BITS        = PREG_BITS_DEFAULT,
    parameter int CTRL_BITS        = CTRL_BITS_DEFAULT,
    localparam int OCC_W           = $clog2(NUM_SLOTS + 1)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  flush,
    input  logic                                  disp_valid,
    output logic                                  disp_ready,
    input  logic [PREG_BITS-1:0]                  disp_src1,
    input  logic                                  disp_p1,
    input  logic [PREG_BITS-1:0]                  disp_src2,
    input  logic                                  disp_p2,
    input  logic [CTRL_BITS-1:0]                  disp_ctrl,
    input  logic [NUM_WAKEUP_PORTS-1:0]           wakeup_valid,
    input  logic [NUM_WAKEUP_PORTS*PREG_BITS-1:0] wakeup_pdst,
    output logic                                  issue_valid,
    input  logic                                  issue_ready,
    output logic [PREG_BITS-1:0]                  issue_src1,
    output logic [PREG_BITS-1:0]                  issue_src2,
    output logic [CTRL_BITS-1:0]                  issue_ctrl,
    output logic [OCC_W-1:0]                      occupancy
);

    logic [OCC_W-1:0]            r_occ;
    logic [WAKEUP_PORTS_MAX-1:0] w_wk_vld;
    logic [WK_PDST_W-1:0]        w_wk_pdst;
    iq_entry_t                   w_disp;
    iq_entry_t                   w_entry [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]        w_ready;
    logic [NUM_SLOTS-1:0]        w_shift;
    logic [NUM_SLOTS-1:0]        w_write;
    logic                        w_any;
    logic [OCC_W-1:0]            w_sel;
    logic [PREG_BITS_DEFAULT-1:0] w_pick_src1;
    logic [PREG_BITS_DEFAULT-1:0] w_pick_src2;
    logic [CTRL_BITS_DEFAULT-1:0] w_pick_ctrl;
    logic                        w_fire;
    logic                        w_accept;
    logic [OCC_W-1:0]            w_wr_idx;

    assign w_wk_vld  = WAKEUP_PORTS_MAX'(wakeup_valid);
    assign w_wk_pdst = WK_PDST_W'(wakeup_pdst);

    always_comb begin
        w_disp       = '0;
        w_disp.valid = 1'b1;
        w_disp.src1  = PREG_BITS_DEFAULT'(disp_src1);
        w_disp.p1    = disp_p1;
        w_disp.src2  = PREG_BITS_DEFAULT'(disp_src2);
        w_disp.p2    = disp_p2;
        w_disp.ctrl  = CTRL_BITS_DEFAULT'(disp_ctrl);
    end

    // Descending scan so the lowest (oldest) ready slot wins.
    always_comb begin
        w_any       = 1'b0;
        w_sel       = '0;
        w_pick_src1 = '0;
        w_pick_src2 = '0;
        w_pick_ctrl = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (w_ready[i]) begin
                w_any       = 1'b1;
                w_sel       = OCC_W'(i);
                w_pick_src1 = w_entry[i].src1;
                w_pick_src2 = w_entry[i].src2;
                w_pick_ctrl = w_entry[i].ctrl;
            end
        end
    end

    assign issue_valid = w_any & ~reset;
    assign issue_src1  = issue_valid ? PREG_BITS'(w_pick_src1) : '0;
    assign issue_src2  = issue_valid ? PREG_BITS'(w_pick_src2) : '0;
    assign issue_ctrl  = issue_valid ? CTRL_BITS'(w_pick_ctrl) : '0;

    assign disp_ready = (r_occ < OCC_W'(NUM_SLOTS)) & ~reset;
    assign w_fire     = issue_valid & issue_ready;
    assign w_accept   = disp_valid & disp_ready;
    assign w_wr_idx   = w_fire ? (r_occ - OCC_W'(1)) : r_occ;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            iq_entry_t w_upper;
            if (gi == NUM_SLOTS - 1) begin : g_top
                assign w_upper = '0;
            end else begin : g_mid
                assign w_upper = w_entry[gi+1];
            end

            assign w_shift[gi] = w_fire & (OCC_W'(gi) >= w_sel);
            assign w_write[gi] = w_accept & (OCC_W'(gi) == w_wr_idx);

            iq_entry u_entry (
                .clk       (clk),
                .i_reset   (reset),
                .i_flush   (flush),
                .i_shift   (w_shift[gi]),
                .i_write   (w_write[gi]),
                .i_upper   (w_upper),
                .i_disp    (w_disp),
                .i_wk_vld  (w_wk_vld),
                .i_wk_pdst (w_wk_pdst),
                .o_entry   (w_entry[gi]),
                .o_ready   (w_ready[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || flush)
            r_occ <= '0;
        else
            r_occ <= r_occ + OCC_W'(w_accept) - OCC_W'(w_fire);
    end

    assign occupancy = r_occ;

endmodule
